led_dim_module: RTL

LED_DIM_MODULE -- requirements
Module: led_dim_module

---
 rtl/led_dim_module_pkg.sv | 17 +
 rtl/led_dim_module_pwm.sv | 109 ++++++++++
 rtl/led_dim_module.sv | 75 +++++++
 3 files changed

// File: rtl/led_dim_module_pkg.sv
// led_pkg: shared constants and types for the LED dimmer.
//   PWM_BITS_DEF  default PWM counter / brightness width
//   PRESCALE_DEF  default clocks per PWM counter step
//   STEP_DEF      default brightness change per button pulse
//   LEVEL_MAX     full-brightness value at the default width
//   ramp_dir_e    breathing ramp direction (used when LED_BREATH_EN is defined)
package led_pkg;
  localparam int PWM_BITS_DEF = 8;
  localparam int PRESCALE_DEF = 4;
  localparam int STEP_DEF     = 16;
  localparam logic [PWM_BITS_DEF-1:0] LEVEL_MAX = '1;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_e;
endpackage

// File: rtl/led_dim_module_pwm.sv
// pwm_module: prescaler, PWM counter, period-boundary duty load and compare.
// Optional macro: LED_BREATH_EN adds the breathing ramp on the active duty.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   level       requested brightness
//   breath_en   (LED_BREATH_EN only) enable breathing ramp
//   ramp_dir    (LED_BREATH_EN only) ramp direction state, for observation
//   pwm_en      combinational PWM enable for the output gating stage
module pwm_module import led_pkg::*; #(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] level,
`ifdef LED_BREATH_EN
  input  logic                breath_en,
  output ramp_dir_e           ramp_dir,
`endif
  output logic                pwm_en
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]     pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] active;
  logic [PWM_BITS-1:0] active_next;
  logic                tick;
  logic                wrap;

  assign tick = (pre_cnt == PS_LAST);
  // The tick that takes pwm_cnt from max back to 0 is the only point where
  // the duty may change, so a period is never cut short or stretched.
  assign wrap = tick && (pwm_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      active  <= CNT_MAX;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) active <= active_next;
    end
  end

  // Max duty is forced fully on; a plain compare would leave one dark slot.
  assign pwm_en = (pwm_cnt < active) || (active == CNT_MAX);

`ifdef LED_BREATH_EN
  logic [PWM_BITS-1:0] ramp;
  logic [PWM_BITS-1:0] ramp_next;
  ramp_dir_e           dir;
  ramp_dir_e           dir_next;

  assign ramp_dir = dir;

  // Duty for the coming period is the current ramp value; the ramp then
  // moves one step, turning around at level (top) and 0 (bottom).
  always_comb begin
    active_next = level;
    ramp_next   = ramp;
    dir_next    = dir;
    if (!breath_en) begin
      ramp_next = '0;
      dir_next  = RAMP_UP;
    end else if (ramp > level) begin
      // Level lowered under the ramp: clamp and head down from there.
      active_next = level;
      ramp_next   = level;
      dir_next    = RAMP_DOWN;
    end else begin
      active_next = ramp;
      if (dir == RAMP_UP) begin
        if (ramp == level) begin
          dir_next  = RAMP_DOWN;
          ramp_next = (ramp == '0) ? '0 : ramp - 1'b1;
        end else begin
          ramp_next = ramp + 1'b1;
        end
      end else begin
        if (ramp == '0) begin
          dir_next  = RAMP_UP;
          ramp_next = (level == '0) ? '0 : PWM_BITS'(1);
        end else begin
          ramp_next = ramp - 1'b1;
        end
      end
    end
  end

  // While breath_en is low the ramp is held at its start point, which also
  // covers the restart on a falling edge of breath_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp <= '0;
      dir  <= RAMP_UP;
    end else if (wrap || !breath_en) begin
      ramp <= ramp_next;
      dir  <= dir_next;
    end
  end
`else
  assign active_next = level;
`endif
endmodule

// File: rtl/led_dim_module.sv
// led_dim_module: brightness register, PWM gating and registered LED drives.
// Optional macro: LED_BREATH_EN adds input Breath_En (breathing ramp).
// Ports:
//   CLK, RST            system clock, synchronous active-high reset
//   Flash_In, Run_In    raw LED levels to be dimmed
//   Bright_Up/Bright_Dn single-cycle brightness pulses (both together: no change)
//   Breath_En           (LED_BREATH_EN only) breathing enable
//   Flash_LED, Run_LED  gated, registered LED drives (one clock latency)
//   Level               current requested brightness
module led_dim_module import led_pkg::*; #(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Flash_In,
  input  logic [2:0]          Run_In,
  input  logic                Bright_Up,
  input  logic                Bright_Dn,
`ifdef LED_BREATH_EN
  input  logic                Breath_En,
`endif
  output logic                Flash_LED,
  output logic [2:0]          Run_LED,
  output logic [PWM_BITS-1:0] Level
);
  // A step larger than the full range behaves like a full-range jump; the
  // clamp keeps the widened arithmetic from truncating it.
  localparam int STEP_C = (STEP > 2**PWM_BITS) ? 2**PWM_BITS : STEP;
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(STEP_C);
  localparam logic [PWM_BITS:0]   LVL_MAX_W = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;

  logic [PWM_BITS:0]   sum_up;
  logic [PWM_BITS-1:0] level_next;
  logic                pwm_en;

  // Saturating add/subtract done one bit wider so overflow is visible.
  always_comb begin
    sum_up     = {1'b0, Level} + STEP_W;
    level_next = Level;
    if (Bright_Up && !Bright_Dn) begin
      level_next = (sum_up > LVL_MAX_W) ? LVL_MAX : sum_up[PWM_BITS-1:0];
    end else if (Bright_Dn && !Bright_Up) begin
      level_next = ({1'b0, Level} < STEP_W) ? '0 : Level - STEP_W[PWM_BITS-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Level     <= LVL_MAX;
      Flash_LED <= 1'b0;
      Run_LED   <= 3'b000;
    end else begin
      Level     <= level_next;
      Flash_LED <= Flash_In & pwm_en;
      Run_LED   <= Run_In & {3{pwm_en}};
    end
  end

  pwm_module #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_pwm (
    .clk       (CLK),
    .rst       (RST),
    .level     (Level),
`ifdef LED_BREATH_EN
    .breath_en (Breath_En),
    .ramp_dir  (),
`endif
    .pwm_en    (pwm_en)
  );
endmodule
